// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-stage FSM states and access-size codes
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memstate_t;

  // funct3[1:0] selects the access size for both loads and stores
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types: data word, control/monitor words, load/store funct3
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // funct3 encodings of the load instructions
  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  // funct3 encodings of the store instructions
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // Control word carried down the pipeline; the memory stage uses
  // data_read, data_write and funct3, the rest rides along to writeback.
  typedef struct packed {
    logic [2:0] funct3;
    logic       data_read;
    logic       data_write;
    logic       regfile_write;
    logic [4:0] rd;
  } rv32i_ctrl_word;

  // Monitor word used by the retirement tracer
  typedef struct packed {
    rv32i_word inst;
    rv32i_word pc;
  } rv32i_mon_word;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-enable and store-lane alignment for one data access
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  funct3_size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  mbe_o,
  output logic [31:0] wdata_o
);

  // Misaligned offsets are not trapped: halves ignore addr[0], words ignore both bits
  always_comb begin
    mbe_o   = 4'b1111;
    wdata_o = rs2_i;
    case (funct3_size_i)
      SIZE_B: begin
        mbe_o   = 4'b0001 << addr_lo_i;
        wdata_o = rs2_i << {addr_lo_i, 3'b000};
      end
      SIZE_H: begin
        mbe_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = rs2_i << {addr_lo_i[1], 4'b0000};
      end
      default: begin
        mbe_o   = 4'b1111;
        wdata_o = rs2_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: request FSM, stall generation, MEM/WB register
module mem_stage
  import rv32i_types::*;
  import mem_stage_pkg::*;
#(
  parameter bit MON_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  rv32i_ctrl_word in_ctrl,
  input  rv32i_mon_word  in_mon,
  input  logic [31:0]    in_alu_out,
  input  logic [31:0]    in_rs2,
  input  logic [31:0]    in_pc_plus4,
  input  logic [31:0]    in_imm,
  input  logic           in_cmp_out,
  input  logic           stall_in,
  output logic           data_read,
  output logic           data_write,
  output logic [31:0]    data_addr,
  output logic [3:0]     data_mbe,
  output logic [31:0]    data_wdata,
  input  logic           data_resp,
  input  logic [31:0]    data_rdata,
  output logic           mem_stall,
  output logic           wb_valid,
  output rv32i_ctrl_word wb_ctrl,
  output rv32i_mon_word  wb_mon,
  output logic [31:0]    wb_alu_out,
  output logic [31:0]    wb_pc_plus4,
  output logic [31:0]    wb_imm,
  output logic [31:0]    wb_rdata,
  output logic           wb_cmp_out,
  output logic [31:0]    wb_mem_addr,
  output logic [31:0]    wb_mem_wdata,
  output logic [3:0]     wb_mem_wmask
);

  logic        memop;
  logic        advance;
  logic [3:0]  al_mbe;
  logic [31:0] al_wdata;
  logic [31:0] req_addr;

  memstate_t   state_q;
  logic        data_read_q;
  logic        data_write_q;
  logic [31:0] data_addr_q;
  logic [3:0]  data_mbe_q;
  logic [31:0] data_wdata_q;
  logic [31:0] hold_q;

  logic [31:0] rdata_d;
  logic [31:0] mon_addr_d;
  logic [31:0] mon_wdata_d;
  logic [3:0]  mon_wmask_d;

  logic           wb_valid_q;
  rv32i_ctrl_word wb_ctrl_q;
  rv32i_mon_word  wb_mon_q;
  logic [31:0]    wb_alu_out_q;
  logic [31:0]    wb_pc_plus4_q;
  logic [31:0]    wb_imm_q;
  logic [31:0]    wb_rdata_q;
  logic           wb_cmp_out_q;
  logic [31:0]    wb_mem_addr_q;
  logic [31:0]    wb_mem_wdata_q;
  logic [3:0]     wb_mem_wmask_q;

  mem_align u_align (
    .funct3_size_i (in_ctrl.funct3[1:0]),
    .addr_lo_i     (in_alu_out[1:0]),
    .rs2_i         (in_rs2),
    .mbe_o         (al_mbe),
    .wdata_o       (al_wdata)
  );

  assign memop    = in_valid && (in_ctrl.data_read || in_ctrl.data_write);
  assign req_addr = {in_alu_out[31:2], 2'b00};

  // The stall lifts in the response cycle itself, so a memop costs issue + response only
  assign mem_stall = memop && !((state_q == REQ && data_resp) || state_q == DONE);
  assign advance   = in_valid && !mem_stall && !stall_in;

  // Request FSM: issue from IDLE, hold in REQ until the response, park in DONE while stalled elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_read_q  <= 1'b0;
      data_write_q <= 1'b0;
      data_addr_q  <= '0;
      data_mbe_q   <= '0;
      data_wdata_q <= '0;
      hold_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memop) begin
            data_read_q  <= in_ctrl.data_read;
            data_write_q <= in_ctrl.data_write;
            data_addr_q  <= req_addr;
            data_mbe_q   <= al_mbe;
            data_wdata_q <= al_wdata;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (data_resp) begin
            data_read_q  <= 1'b0;
            data_write_q <= 1'b0;
            if (stall_in) begin
              hold_q  <= data_rdata;
              state_q <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          if (!stall_in) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          data_read_q  <= 1'b0;
          data_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_read  = data_read_q;
  assign data_write = data_write_q;
  assign data_addr  = data_addr_q;
  assign data_mbe   = data_mbe_q;
  assign data_wdata = data_wdata_q;

  // Load data comes straight off the bus in REQ, or from the hold register after a parked response
  always_comb begin
    rdata_d = '0;
    if (memop && in_ctrl.data_read) begin
      rdata_d = (state_q == DONE) ? hold_q : data_rdata;
    end
  end

  // Monitor view of the access; zero for non-memops, write fields zero for loads
  always_comb begin
    mon_addr_d  = '0;
    mon_wdata_d = '0;
    mon_wmask_d = '0;
    if (MON_EN && memop) begin
      mon_addr_d = req_addr;
      if (in_ctrl.data_write) begin
        mon_wdata_d = al_wdata;
        mon_wmask_d = al_mbe;
      end
    end
  end

  // MEM/WB register: loads on advance, otherwise inserts a bubble with a cleared control word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_ctrl_q      <= '0;
      wb_mon_q       <= '0;
      wb_alu_out_q   <= '0;
      wb_pc_plus4_q  <= '0;
      wb_imm_q       <= '0;
      wb_rdata_q     <= '0;
      wb_cmp_out_q   <= 1'b0;
      wb_mem_addr_q  <= '0;
      wb_mem_wdata_q <= '0;
      wb_mem_wmask_q <= '0;
    end else if (advance) begin
      wb_valid_q     <= 1'b1;
      wb_ctrl_q      <= in_ctrl;
      wb_mon_q       <= in_mon;
      wb_alu_out_q   <= in_alu_out;
      wb_pc_plus4_q  <= in_pc_plus4;
      wb_imm_q       <= in_imm;
      wb_rdata_q     <= rdata_d;
      wb_cmp_out_q   <= in_cmp_out;
      wb_mem_addr_q  <= mon_addr_d;
      wb_mem_wdata_q <= mon_wdata_d;
      wb_mem_wmask_q <= mon_wmask_d;
    end else begin
      wb_valid_q <= 1'b0;
      wb_ctrl_q  <= '0;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_ctrl      = wb_ctrl_q;
  assign wb_mon       = wb_mon_q;
  assign wb_alu_out   = wb_alu_out_q;
  assign wb_pc_plus4  = wb_pc_plus4_q;
  assign wb_imm       = wb_imm_q;
  assign wb_rdata     = wb_rdata_q;
  assign wb_cmp_out   = wb_cmp_out_q;
  assign wb_mem_addr  = wb_mem_addr_q;
  assign wb_mem_wdata = wb_mem_wdata_q;
  assign wb_mem_wmask = wb_mem_wmask_q;

endmodule
